// File: rtl/tdigits_to_tc.sv
// rtl/tdigits_to_tc.sv - signed BCD temperature entry (C or F) to 13-bit two's-complement Celsius
// One conversion at a time; F entries go through (v-32)*5 and a bit-serial divide by 9.
module tdigits_to_tc (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sign,
  input  logic               c_f,
  input  logic [3:0]         thou,
  input  logic [3:0]         hund,
  input  logic [3:0]         tens,
  input  logic [3:0]         ones,
  output logic               ready,
  output logic               valid,
  output logic signed [12:0] tc,
  output logic               ovf,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, CHECK, ACC, SIGN, OFFS, DIV, SAT, DONE} state_t;

  state_t             state, next_state;
  logic               sign_r, cf_r, neg;
  logic [15:0]        digits_r;
  logic [13:0]        acc, acc_next;
  logic [3:0]         cnt, digit, rem, rem_sub;
  logic [4:0]         trial;
  logic [15:0]        dq;
  logic signed [17:0] val, offs, res;
  logic               bad_digit;

  always_comb begin
    digit = digits_r[3:0];
    case (cnt[1:0])
      2'd0:    digit = digits_r[15:12];
      2'd1:    digit = digits_r[11:8];
      2'd2:    digit = digits_r[7:4];
      default: digit = digits_r[3:0];
    endcase
  end

  always_comb begin
    bad_digit = (digits_r[15:12] > 4'd9) || (digits_r[11:8] > 4'd9) ||
                (digits_r[7:4] > 4'd9) || (digits_r[3:0] > 4'd9);
    acc_next  = acc * 14'd10 + {10'd0, digit};
    offs      = (val - 18'sd32) * 18'sd5;
    // Remainder is always < 9, so 4 bits plus the incoming dividend bit suffice.
    trial     = {rem, dq[15]};
    rem_sub   = trial[3:0] - 4'd9;
    if (cf_r)
      res = neg ? -$signed({2'b00, dq}) : $signed({2'b00, dq});
    else
      res = val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CHECK;
      CHECK:   next_state = bad_digit ? DONE : ACC;
      ACC:     if (cnt == 4'd3) next_state = SIGN;
      SIGN:    next_state = cf_r ? OFFS : SAT;
      OFFS:    next_state = DIV;
      DIV:     if (cnt == 4'd15) next_state = SAT;
      SAT:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_r   <= 1'b0;
      cf_r     <= 1'b0;
      neg      <= 1'b0;
      digits_r <= 16'd0;
      acc      <= 14'd0;
      cnt      <= 4'd0;
      rem      <= 4'd0;
      dq       <= 16'd0;
      val      <= 18'sd0;
      tc       <= 13'sd0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sign_r   <= sign;
          cf_r     <= c_f;
          digits_r <= {thou, hund, tens, ones};
        end
        CHECK: begin
          acc <= 14'd0;
          cnt <= 4'd0;
          if (bad_digit) begin
            tc  <= 13'sd0;
            ovf <= 1'b0;
            err <= 1'b1;
          end
        end
        ACC: begin
          acc <= acc_next;
          cnt <= (cnt == 4'd3) ? 4'd0 : cnt + 4'd1;
        end
        SIGN: val <= sign_r ? -$signed({4'd0, acc}) : $signed({4'd0, acc});
        OFFS: begin
          val <= offs;
          neg <= offs[17];
          dq  <= offs[17] ? 16'(-offs) : offs[15:0];
          rem <= 4'd0;
          cnt <= 4'd0;
        end
        DIV: begin
          cnt <= cnt + 4'd1;
          if (trial >= 5'd9) begin
            rem <= rem_sub;
            dq  <= {dq[14:0], 1'b1};
          end else begin
            rem <= trial[3:0];
            dq  <= {dq[14:0], 1'b0};
          end
        end
        SAT: begin
          err <= 1'b0;
          if (res > 18'sd4095) begin
            tc  <= 13'sd4095;
            ovf <= 1'b1;
          end else if (res < -18'sd4096) begin
            tc  <= -13'sd4096;
            ovf <= 1'b1;
          end else begin
            tc  <= res[12:0];
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdigits_to_tc.sv
// tb/tb_tdigits_to_tc.sv - scoreboard bench for tdigits_to_tc
// Expected results come from integer arithmetic on the entered value.
module tb_tdigits_to_tc;

  logic               clk = 1'b0;
  logic               reset, start, sign, c_f;
  logic [3:0]         thou, hund, tens, ones;
  logic               ready, valid, ovf, err;
  logic signed [12:0] tc;

  tdigits_to_tc dut (
    .clk(clk), .reset(reset), .start(start), .sign(sign), .c_f(c_f),
    .thou(thou), .hund(hund), .tens(tens), .ones(ones),
    .ready(ready), .valid(valid), .tc(tc), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tc;
    bit ovf;
    bit err;
    int t0;
    int lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input bit s, input bit f,
                                 input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] c, input logic [3:0] d);
    exp_t e;
    int   v;
    e.t0 = 0;
    if (a > 9 || b > 9 || c > 9 || d > 9) begin
      e.tc = 0; e.ovf = 0; e.err = 1; e.lat = 2;
      return e;
    end
    v = a * 1000 + b * 100 + c * 10 + d;
    if (s) v = -v;
    if (f) v = ((v - 32) * 5) / 9;
    e.err = 0;
    e.lat = f ? 25 : 8;
    if (v > 4095)       begin e.tc = 4095;  e.ovf = 1; end
    else if (v < -4096) begin e.tc = -4096; e.ovf = 1; end
    else                begin e.tc = v;     e.ovf = 0; end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("tc", int'(tc), e.tc);
        check("ovf", int'(ovf), int'(e.ovf));
        check("err", int'(err), int'(e.err));
        check("valid_cycle", cyc - e.t0, e.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge of cycle 1 with inputs scrambled.
  task automatic issue(input bit s, input bit f, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d, input bit push,
                       output int t0, output int ready_lat);
    exp_t e;
    int   n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
    sign = s; c_f = f; thou = a; hund = b; tens = c; ones = d;
    start = 1'b1;
    t0 = cyc;
    e = model(s, f, a, b, c, d);
    e.t0 = t0;
    ready_lat = e.lat + 1;
    if (push) q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    sign = 1'($urandom); c_f = 1'($urandom);
    thou = 4'($urandom); hund = 4'($urandom); tens = 4'($urandom); ones = 4'($urandom);
  endtask

  task automatic finish_wait(input int t0, input int ready_lat);
    int n = 0;
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ready_cycle", cyc - t0, ready_lat);
  endtask

  task automatic conv(input bit s, input bit f, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    int t0, rl;
    issue(s, f, a, b, c, d, 1'b1, t0, rl);
    finish_wait(t0, rl);
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 15) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    int t0, rl, n;
    reset = 1'b1; start = 1'b0; sign = 1'b0; c_f = 1'b0;
    thou = 4'd0; hund = 4'd0; tens = 4'd0; ones = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_ready", int'(ready), 1);
    check("reset_valid", int'(valid), 0);
    check("reset_tc", int'(tc), 0);
    check("reset_ovf", int'(ovf), 0);
    check("reset_err", int'(err), 0);
    reset = 1'b0;
    @(negedge clk);

    conv(1, 0, 0, 2, 5, 6);
    conv(0, 0, 0, 2, 5, 5);
    conv(0, 1, 0, 2, 1, 2);
    conv(1, 1, 0, 0, 4, 0);
    conv(0, 1, 0, 0, 0, 0);
    conv(1, 0, 0, 0, 0, 0);
    conv(0, 0, 5, 0, 0, 0);
    conv(1, 0, 4, 0, 9, 6);
    conv(1, 0, 4, 0, 9, 7);
    conv(0, 1, 9, 9, 9, 9);
    conv(0, 0, 0, 1, 4'hA, 3);
    conv(0, 0, 0, 1, 2, 3);

    // Starts while busy must be ignored; the next start lands on the first ready cycle.
    issue(0, 1, 0, 2, 1, 2, 1'b1, t0, rl);
    repeat (2) @(negedge clk);
    start = 1'b1; sign = 1'b1; c_f = 1'b0; thou = 4'd9; hund = 4'd9; tens = 4'd9; ones = 4'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1; sign = 1'b0; c_f = 1'b1; thou = 4'd1; hund = 4'd2; tens = 4'd3; ones = 4'd4;
    @(negedge clk);
    start = 1'b0;
    finish_wait(t0, rl);
    conv(1, 1, 0, 1, 0, 0);

    conv(0, 0, 5, 0, 0, 0);
    issue(0, 1, 0, 3, 0, 0, 1'b0, t0, rl);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_tc", int'(tc), 0);
    check("abort_ovf", int'(ovf), 0);
    check("abort_err", int'(err), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_ready", int'(ready), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_abort_ready", int'(ready), 1);
    repeat (30) @(negedge clk);
    conv(0, 0, 0, 0, 2, 0);

    reset = 1'b1; start = 1'b1; c_f = 1'b0;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset_start_ready", int'(ready), 1);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 40; i++)
      conv(1'($urandom), 1'($urandom), rand_digit(), rand_digit(), rand_digit(), rand_digit());

    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
